// File: rtl/master_i2c.sv
// master_i2c: single-byte I2C bus master.
// Runs one transaction per command: START, {addr,rw}, slave ACK, one data
// byte (written by the master or read from the slave), ACK/NACK, STOP.
// Every bit slot is four quarters of CLK_DIV clk cycles each, so SCL is
// low for the first half of a slot and high for the second half.
//
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   start      command strobe, only honoured while busy=0
//   addr, rw   7-bit target address and direction (1 = read)
//   wdata      byte to write, captured together with start
//   scl        push-pull SCL
//   sda        open-drain SDA (driven low or released to high-Z)
//   busy       a transaction is in progress
//   done       one-cycle pulse when the transaction ends
//   ack_err    sticky: a required ACK was missing in the last transaction
//   rdata      byte read by the last completed read
`timescale 1ns/1ps
module master_i2c #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [1:0]    q_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q, wdata_q, rx_q, rdata_q;
  logic          rw_q, ack_ok_q, ack_err_q, done_q;
  logic          qt, smp, slot_end, sda_in, sda_low, scl_c;

  assign sda_in   = sda;
  // Divider is parked in IDLE, so gate the tick there (matters for CLK_DIV=1).
  assign qt       = (state_q != S_IDLE) && (div_q == DIV_MAX);
  assign smp      = qt && (q_q == 2'd2);  // end of q2: SCL high and settled
  assign slot_end = qt && (q_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      q_q       <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      ack_ok_q  <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        div_q <= '0;
        q_q   <= '0;
        bit_q <= '0;
        if (start) begin
          shreg_q   <= {addr, rw};
          wdata_q   <= wdata;
          rw_q      <= rw;
          ack_err_q <= 1'b0;
        end
      end else begin
        div_q <= qt ? '0 : div_q + DW'(1);
        if (qt) q_q <= q_q + 2'd1;
        case (state_q)
          S_ADDR: if (slot_end) begin
            shreg_q <= {shreg_q[6:0], 1'b0};
            bit_q   <= bit_q + 3'd1;   // wraps to 0 after bit 7
          end
          S_ACK1: begin
            if (smp) begin
              ack_ok_q <= ~sda_in;
              if (sda_in) ack_err_q <= 1'b1;
            end
            if (slot_end && !rw_q) shreg_q <= wdata_q;
          end
          S_DATA: begin
            if (slot_end) begin
              bit_q <= bit_q + 3'd1;
              if (!rw_q) shreg_q <= {shreg_q[6:0], 1'b0};
            end
            if (smp && rw_q) rx_q <= {rx_q[6:0], sda_in};
          end
          S_ACK2: begin
            if (smp && !rw_q && sda_in) ack_err_q <= 1'b1;
            if (slot_end && rw_q) rdata_q <= rx_q;
          end
          S_STOP: if (slot_end) done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scl_c   = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_START;
      S_START: begin
        scl_c   = (q_q != 2'd3);
        sda_low = (q_q != 2'd0);       // SDA falls in q1 with SCL high
        if (slot_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_c   = q_q[1];
        sda_low = ~shreg_q[7];
        if (slot_end && bit_q == 3'd7) state_d = S_ACK1;
      end
      S_ACK1: begin
        scl_c = q_q[1];
        if (slot_end) state_d = ack_ok_q ? S_DATA : S_STOP;
      end
      S_DATA: begin
        scl_c   = q_q[1];
        sda_low = !rw_q && !shreg_q[7];
        if (slot_end && bit_q == 3'd7) state_d = S_ACK2;
      end
      S_ACK2: begin
        scl_c = q_q[1];                // read: SDA left released = NACK
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        scl_c   = (q_q != 2'd0);
        sda_low = (q_q < 2'd2);        // SDA rises in q2 with SCL high
        if (slot_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign scl     = scl_c;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_master_i2c.sv
`timescale 1ns/1ps
module tb_master_i2c;
  localparam int         CLK_DIV = 4;
  localparam logic [6:0] SLV     = 7'h42;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       scl, busy, done, ack_err;
  logic [7:0] rdata;
  wire        sda;
  logic       slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);

  // second master at the fastest divider on its own device-less bus
  logic       start1 = 1'b0, rw1 = 1'b0;
  logic [6:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       scl1, busy1, done1, ack_err1;
  logic [7:0] rdata1;
  wire        sda1;
  pullup (sda1);

  master_i2c #(.CLK_DIV(CLK_DIV)) u_dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .scl(scl), .sda(sda), .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata));

  master_i2c #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .addr(addr1), .rw(rw1), .wdata(wdata1),
    .scl(scl1), .sda(sda1), .busy(busy1), .done(done1), .ack_err(ack_err1), .rdata(rdata1));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave device model at SLV ----------------
  localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_WDATA = 3, P_DACK = 4,
                 P_RDATA = 5, P_MACK = 6, P_WAIT = 7;
  logic       dack = 1'b1;
  logic [7:0] rbyte = '0;
  int         phase = P_IDLE, nb = 0, rbits = 0, starts = 0, stops = 0;
  logic [7:0] sh = '0;
  logic       rd_q = 1'b0, pscl = 1'b1, psda = 1'b1;
  logic [8:0] rec_a = 9'h100, rec_w = 9'h100;
  logic [1:0] rec_m = 2'd2;

  always @(negedge clk) begin
    pscl <= scl;
    psda <= sda;
    if (rst) begin
      phase   <= P_IDLE;
      slv_low <= 1'b0;
    end else if (pscl && scl && psda && !sda) begin
      starts <= starts + 1;
      phase  <= P_ADDR;
      nb     <= 0;
      rec_a  <= 9'h100;
      rec_w  <= 9'h100;
      rec_m  <= 2'd2;
    end else if (pscl && scl && !psda && sda) begin
      stops   <= stops + 1;
      phase   <= P_IDLE;
      slv_low <= 1'b0;
    end else if (!pscl && scl) begin
      if (phase == P_ADDR || phase == P_WDATA) begin
        sh <= {sh[6:0], sda};
        nb <= nb + 1;
      end else if (phase == P_MACK) begin
        rec_m <= {1'b0, sda};
        phase <= P_WAIT;
      end
    end else if (pscl && !scl) begin
      case (phase)
        P_ADDR: if (nb == 8) begin
          rec_a <= {1'b0, sh};
          if (sh[7:1] == SLV) begin
            slv_low <= 1'b1;
            rd_q    <= sh[0];
            phase   <= P_AACK;
          end else phase <= P_WAIT;
        end
        P_AACK: if (rd_q) begin
          slv_low <= ~rbyte[7];
          rbits   <= 1;
          phase   <= P_RDATA;
        end else begin
          slv_low <= 1'b0;
          nb      <= 0;
          phase   <= P_WDATA;
        end
        P_WDATA: if (nb == 8) begin
          rec_w   <= {1'b0, sh};
          slv_low <= dack;
          phase   <= P_DACK;
        end
        P_DACK: begin
          slv_low <= 1'b0;
          phase   <= P_WAIT;
        end
        P_RDATA: if (rbits == 8) begin
          slv_low <= 1'b0;
          phase   <= P_MACK;
        end else begin
          slv_low <= ~rbyte[7 - rbits];
          rbits   <= rbits + 1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- observer of the CLK_DIV=1 bus ----------------
  int         starts1 = 0, stops1 = 0, nrise1 = 0, last_rise1 = 0;
  logic       pscl1 = 1'b1, psda1 = 1'b1, per_err1 = 1'b0;
  logic [7:0] sh1 = '0;
  always @(negedge clk) begin
    pscl1 <= scl1;
    psda1 <= sda1;
    if (!rst) begin
      if (pscl1 && scl1 && psda1 && !sda1) begin
        starts1 <= starts1 + 1;
        nrise1  <= 0;
      end else if (pscl1 && scl1 && !psda1 && sda1) begin
        stops1 <= stops1 + 1;
      end else if (!pscl1 && scl1) begin
        nrise1     <= nrise1 + 1;
        last_rise1 <= cyc;
        if (nrise1 < 8) sh1 <= {sh1[6:0], sda1};
        // 8 address bits + ACK clock are back-to-back 4-clk slots
        if (nrise1 >= 1 && nrise1 <= 8 && cyc - last_rise1 != 4) per_err1 <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [8:0] abyte;
    logic       chk_w;
    logic [7:0] wbyte;
    logic       chk_m;
    logic       ack_err;
    logic [7:0] rdata;
    int         len;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] mdl_rdata = '0;
  int         exp_starts = 0, exp_stops = 0;

  initial begin : mon
    exp_t e;
    logic pbusy;
    int   t0;
    pbusy = 1'b0;
    t0    = 0;
    forever begin
      @(negedge clk);
      if (busy && !pbusy) t0 = cyc;
      pbusy = busy;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("addr_byte", rec_a, e.abyte);
          if (e.chk_w) chk("write_byte", rec_w, {1'b0, e.wbyte});
          if (e.chk_m) chk("master_nack", rec_m, 2'd1);
          chk("ack_err", ack_err, e.ack_err);
          chk("rdata", rdata, e.rdata);
          chk("length", cyc - t0, e.len);
        end
      end
    end
  end

  // Reference: what the transaction must look like from the bus rules alone.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic da, input logic [7:0] rb, input logic glitch);
    exp_t e;
    logic hit;
    dack  = da;
    rbyte = rb;
    hit   = (a == SLV);
    e.abyte   = {1'b0, a, r};
    e.chk_w   = hit && !r;
    e.wbyte   = wd;
    e.chk_m   = hit && r;
    e.ack_err = !hit || (!r && !da);
    if (hit && r) mdl_rdata = rb;
    e.rdata   = mdl_rdata;
    // START + address byte + ACK (+ data byte + ACK) + STOP, in bit slots of 4 quarters
    e.len     = CLK_DIV * (hit ? (4 + 32 + 4 + 32 + 4 + 4) : (4 + 32 + 4 + 4));
    exp_q.push_back(e);
    exp_starts++;
    exp_stops++;
    @(negedge clk);
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch) begin
      repeat (20) @(negedge clk);
      addr = 7'h11; rw = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("txn_timeout", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin : stim
    logic [6:0] ra;
    int         t1, len1;
    logic       got;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy1", busy1, 0);

    run_txn(SLV,   1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);  // write, both ACKed
    run_txn(SLV,   1'b1, 8'h00, 1'b1, 8'h3C, 1'b0);  // read 0x3C
    run_txn(7'h11, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0);  // no device
    run_txn(SLV,   1'b0, 8'hC3, 1'b0, 8'h00, 1'b0);  // data NACKed
    run_txn(SLV,   1'b0, 8'h96, 1'b1, 8'h00, 1'b1);  // start pulses while busy

    // reset in the middle of the data byte
    exp_starts++;
    dack = 1'b1;
    @(negedge clk);
    addr = SLV; rw = 1'b0; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ((4 + 32 + 4 + 12 + 1) * CLK_DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda", sda, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    mdl_rdata = '0;
    @(negedge clk);
    chk("midrst_ack_err", ack_err, 0);
    chk("midrst_rdata", rdata, 0);
    run_txn(SLV, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);

    for (int k = 0; k < 16; k++) begin
      ra = ($urandom_range(0, 3) != 0) ? SLV : 7'($urandom_range(0, 127));
      run_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              8'($urandom), 1'b0);
    end

    // CLK_DIV=1 master, no device, second start while busy
    @(negedge clk);
    addr1 = 7'h11; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    t1 = cyc;
    chk("dut1_busy", busy1, 1);
    repeat (10) @(negedge clk);
    addr1 = 7'h55; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    got  = 1'b0;
    len1 = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done1) begin
        len1 = cyc - t1;
        got  = 1'b1;
        break;
      end
    end
    chk("dut1_done_seen", got, 1);
    chk("dut1_length", len1, 4 + 32 + 4 + 4);
    chk("dut1_ack_err", ack_err1, 1);
    repeat (60) @(negedge clk);
    chk("dut1_idle", busy1, 0);
    chk("dut1_starts", starts1, 1);
    chk("dut1_stops", stops1, 1);
    chk("dut1_addr_byte", sh1, {7'h11, 1'b0});
    chk("dut1_bit_period", per_err1, 0);

    chk("start_count", starts, exp_starts);
    chk("stop_count", stops, exp_stops);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
